// File: rtl/sync_event_rx.sv
// sync_event_rx
// Receive-side event synchronizer for the out-domain clock. Each of the NCH
// asynchronous inputs passes through an NSYNC-flop synchronizer. Edges that
// qualify under EDGE_MODE become single-cycle pulses, and each channel keeps
// sticky pending and overrun flags plus an optional saturating event counter.
//
// Optional feature macro: SYNC_EVT_CNT_EN
//   defined   : per-channel saturating event counters drive evt_cnt
//   undefined : no counter registers; evt_cnt is tied to 0
//
// Parameters:
//   NCH       number of event channels (1..32)
//   NSYNC     synchronizer flops per channel (2..4)
//   EDGE_MODE 0 = any edge, 1 = rising only, 2 = falling only
//   CNT_W     event counter width per channel
//
// Ports:
//   clk       out-domain clock, rising edge
//   rst_n     asynchronous active-low reset
//   evt_in    asynchronous event levels/toggles, one bit per channel
//   clr       synchronous per-channel clear of pend/overrun/count
//   evt_pulse one-clk pulse per detected event
//   evt_pend  sticky event-pending flag
//   overrun   sticky flag: event arrived while pend was already set
//   armed     high once post-reset priming is complete
//   evt_cnt   per-channel saturating count, channel i at [i*CNT_W +: CNT_W]
//
// State  | meaning
// -------+------------------------------------------------------------------
// PRIME  | after reset; edge reference tracks the synced value, no events
// ARMED  | edge detection active; reference follows synced every cycle
module sync_event_rx #(
  parameter int NCH       = 4,
  parameter int NSYNC     = 2,
  parameter int EDGE_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       evt_in,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       evt_pulse,
  output logic [NCH-1:0]       evt_pend,
  output logic [NCH-1:0]       overrun,
  output logic                 armed,
  output logic [NCH*CNT_W-1:0] evt_cnt
);

  localparam int PW = $clog2(NSYNC + 1);

  typedef enum logic {
    ST_PRIME,
    ST_ARMED
  } state_t;

  state_t         state;
  logic [PW-1:0]  prime_cnt;
  logic [NCH-1:0] sync_q [NSYNC];
  logic [NCH-1:0] synced;
  logic [NCH-1:0] ref_q;
  logic [NCH-1:0] detect;

  // Plain flop chain; nothing may sit between the synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSYNC; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= evt_in;
      for (int k = 1; k < NSYNC; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign synced = sync_q[NSYNC-1];

  generate
    if (EDGE_MODE == 1) begin : g_rise
      assign detect = synced & ~ref_q;
    end else if (EDGE_MODE == 2) begin : g_fall
      assign detect = ~synced & ref_q;
    end else begin : g_any
      assign detect = synced ^ ref_q;
    end
  endgenerate

  // Priming lets the chain fill and the reference settle on the real input
  // level, so an input already high at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
      armed     <= 1'b0;
      ref_q     <= '0;
      evt_pulse <= '0;
    end else begin
      ref_q <= synced;
      case (state)
        ST_PRIME: begin
          evt_pulse <= '0;
          if (prime_cnt == PW'(NSYNC)) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end else begin
            prime_cnt <= prime_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          evt_pulse <= detect;
        end
        default: begin
          state     <= ST_PRIME;
          evt_pulse <= '0;
        end
      endcase
    end
  end

  // An event is the registered pulse. Set beats clear for pend; clear beats
  // set for overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pend <= '0;
      overrun  <= '0;
    end else begin
      overrun  <= ~clr & (overrun | (evt_pulse & evt_pend));
      evt_pend <= evt_pulse | (evt_pend & ~clr);
    end
  end

`ifdef SYNC_EVT_CNT_EN
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (clr[i]) begin
          // A clear that coincides with an event leaves a count of one.
          cnt_q <= CNT_W'(evt_pulse[i]);
        end else if (evt_pulse[i] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_event_rx.sv
module tb_sync_event_rx;

  localparam int NCH       = 4;
  localparam int NSYNC     = 2;
  localparam int EDGE_MODE = 0;
  localparam int CNT_W     = 8;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       evt_in = '1;
  logic [NCH-1:0]       clr = '0;
  logic [NCH-1:0]       evt_pulse;
  logic [NCH-1:0]       evt_pend;
  logic [NCH-1:0]       overrun;
  logic                 armed;
  logic [NCH*CNT_W-1:0] evt_cnt;

  sync_event_rx #(
    .NCH(NCH), .NSYNC(NSYNC), .EDGE_MODE(EDGE_MODE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .clr(clr),
    .evt_pulse(evt_pulse), .evt_pend(evt_pend), .overrun(overrun),
    .armed(armed), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [NCH-1:0] mask;
  } exp_t;

  exp_t           exp_q[$];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             rel = 0;
  logic [NCH-1:0] lvl = '1;
  logic [NCH-1:0] m_pend = '0;
  logic [NCH-1:0] m_ovr = '0;
  int             m_cnt [NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) rel++;
  end

  // Reset discards everything in flight and restarts the model.
  always @(negedge rst_n) begin
    exp_q.delete();
    m_pend = '0;
    m_ovr  = '0;
    rel    = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  end

  // Monitor: compare what the DUT shows after each edge, then advance the
  // model by the rules for the next edge using the clr now being presented.
  always @(negedge clk) begin
    logic [NCH-1:0] exp_pulse;
    exp_pulse = '0;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_pulse |= exp_q[0].mask;
      void'(exp_q.pop_front());
    end
    check("pulse", 64'(evt_pulse), 64'(exp_pulse));
    check("pend", 64'(evt_pend), 64'(m_pend));
    check("overrun", 64'(overrun), 64'(m_ovr));
    check("armed", 64'(armed), 64'(rst_n && (rel >= NSYNC + 1)));
    for (int i = 0; i < NCH; i++)
      check("cnt", 64'(evt_cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
    if (rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_ovr[i]  = clr[i] ? 1'b0 : (m_ovr[i] | (exp_pulse[i] & m_pend[i]));
        m_pend[i] = exp_pulse[i] | (m_pend[i] & ~clr[i]);
`ifdef SYNC_EVT_CNT_EN
        if (clr[i]) m_cnt[i] = exp_pulse[i] ? 1 : 0;
        else if (exp_pulse[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called 2 time units after edge cyc; the new level is captured at edge
  // cyc+1, so a qualifying change pulses after edge cyc+1+NSYNC.
  task automatic set_evt(input logic [NCH-1:0] v);
    logic [NCH-1:0] mask;
    mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] != lvl[i]) begin
        if (EDGE_MODE == 0 || (EDGE_MODE == 1 && v[i]) || (EDGE_MODE == 2 && !v[i]))
          mask[i] = 1'b1;
      end
    end
    lvl    = v;
    evt_in = v;
    if (mask != '0) exp_q.push_back('{due: cyc + 1 + NSYNC, mask: mask});
  endtask

  task automatic fire(input int ch, output int due);
    logic [NCH-1:0] v;
    if (EDGE_MODE != 0 && lvl[ch] == (EDGE_MODE == 1)) begin
      v = lvl;
      v[ch] = ~v[ch];
      set_evt(v);
      tick(NSYNC + 2);
    end
    v = lvl;
    v[ch] = ~v[ch];
    due = cyc + 1 + NSYNC;
    set_evt(v);
  endtask

  task automatic release_reset();
    lvl   = evt_in;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int  d;
    int  n;
    bit  got;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;

    // Reset with all inputs already high: no events may follow release.
    #3;
    check("rst_pulse", 64'(evt_pulse), 64'(0));
    check("rst_armed", 64'(armed), 64'(0));
    tick(3);
    release_reset();
    tick(NSYNC);
    check("armed_early", 64'(armed), 64'(0));
    tick(1);
    check("armed_rise", 64'(armed), 64'(1));
    tick(NSYNC + 4);
    check("no_spurious_pend", 64'(evt_pend), 64'(0));

    // Single channel, two events: second one sets overrun.
    fire(2, d);
    tick(10);
    fire(2, d);
    tick(NSYNC + 4);

    // Clear coinciding with an event while pending.
    fire(1, d);
    tick(NSYNC + 2);
    fire(1, d);
    tick(NSYNC + 1);
    clr = 4'b0010;
    tick(1);
    clr = '0;
    check("clr_evt_pend", 64'(evt_pend[1]), 64'(1));
    check("clr_evt_ovr", 64'(overrun[1]), 64'(0));
`ifdef SYNC_EVT_CNT_EN
    check("clr_evt_cnt", 64'(evt_cnt[CNT_W +: CNT_W]), 64'(1));
`else
    check("clr_evt_cnt", 64'(evt_cnt[CNT_W +: CNT_W]), 64'(0));
`endif
    tick(NSYNC + 2);

    // Randomized multi-channel traffic with sparse clears.
    for (int it = 0; it < 80; it++) begin
      set_evt(NCH'($urandom));
      for (int w = 0; w < NSYNC + 2; w++) begin
        clr = NCH'($urandom & $urandom & $urandom);
        tick(1);
      end
    end
    clr = '0;
    tick(NSYNC + 3);

    // Saturation on channel 3, then clear.
    for (int it = 0; it < 2 * (CMAX + 1) + 8; it++) begin
      set_evt(lvl ^ NCH'(8));
      tick(NSYNC + 2);
    end
    tick(2);
`ifdef SYNC_EVT_CNT_EN
    check("sat_cnt", 64'(evt_cnt[3*CNT_W +: CNT_W]), 64'(CMAX));
`else
    check("sat_cnt", 64'(evt_cnt[3*CNT_W +: CNT_W]), 64'(0));
`endif
    clr = 4'b1000;
    tick(1);
    clr = '0;
    tick(1);
    check("sat_clr", 64'(evt_cnt[3*CNT_W +: CNT_W]), 64'(0));
    tick(NSYNC + 2);

    // Asynchronous reset while a pulse is high.
    fire(0, d);
    got = 1'b0;
    n = 0;
    while (n < NSYNC + 8 && !got) begin
      @(negedge clk);
      if (evt_pulse[0]) got = 1'b1;
      n++;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rst_wait: evt_pulse[0] got 0 expected 1 within %0d cycles", NSYNC + 8);
    end
    #1 rst_n = 1'b0;
    #1;
    check("async_pulse", 64'(evt_pulse), 64'(0));
    check("async_pend", 64'(evt_pend), 64'(0));
    check("async_armed", 64'(armed), 64'(0));
    tick(3);
    release_reset();
    tick(NSYNC + 6);
    fire(3, d);
    tick(NSYNC + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_event_rx.md
Name: sync_event_rx

Overview:
- Multi-channel receive-side event synchronizer for the out_clk domain.
- Takes NCH asynchronous level or toggle signals from foreign domains and runs each through an NSYNC-flop synchronizer.
- Converts detected transitions into single-cycle pulses, sticky pending flags and overrun flags, with optional saturating event counters.
- Replaces the per-flag ad-hoc toggle-synchronizer instances feeding the CPU status/interrupt logic.

Parameters:
NCH, 4, number of independent event channels (1..32)
NSYNC, 2, synchronizer flops per channel (2..4)
EDGE_MODE, 0, 0 = toggle (any edge is an event), 1 = rising edge only, 2 = falling edge only; applies to all channels
CNT_W, 8, event counter width per channel (used only with SYNC_EVT_CNT_EN)

Ports:
clk  in  1  out-domain clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
evt_in  in  NCH  asynchronous event levels/toggles, one bit per channel
clr  in  NCH  synchronous per-channel clear of pend/overrun/count
evt_pulse  out  NCH  one-clk pulse per detected event
evt_pend  out  NCH  sticky event-pending flag
overrun  out  NCH  sticky: event arrived while pend already set
armed  out  1  high once post-reset priming is complete
evt_cnt  out  NCH*CNT_W  per-channel saturating event count; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low, async): sync chains, edge reference, evt_pulse, evt_pend, overrun, evt_cnt and armed all 0; prime counter 0.
- Sync chain: s[0] <= evt_in; s[k] <= s[k-1]; the synced value is s[NSYNC-1]. No logic between sync flops.
- Priming: after rst_n deasserts, a prime counter counts NSYNC+1 clk edges.
  - While priming, ref <= synced value every cycle; no events are generated.
  - armed rises on the edge that ends priming and stays 1 until reset.
  - This prevents a spurious event when evt_in is already 1 at reset release.
- Edge detect (armed = 1): ref <= synced every cycle. The detect term is, per EDGE_MODE:
  - mode 0: synced ^ ref
  - mode 1: synced & ~ref
  - mode 2: ~synced & ref
- evt_pulse is registered from the detect term: high for exactly one cycle per qualifying transition.
- Latency: evt_in stable before edge E0 produces evt_pulse high in the cycle after edge E(NSYNC), i.e. NSYNC+1 edges.
- Input rule: each channel's transitions must be spaced ≥ NSYNC+2 clk periods. Closer transitions may merge; no guarantee is made.
- evt_pend[i]:
  - set by an event, cleared by clr[i].
  - Event and clr in the same cycle: pend = 1 (set wins).
- overrun[i]:
  - set when an event occurs while pend = 1 and clr[i] = 0; cleared by clr[i].
  - clr and event in the same cycle: overrun = 0.
- clr during priming: clears flags; has no effect on priming.
- Reset mid-operation: all state returns to reset values and priming restarts; events in flight are discarded.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

Optional Feature:
- SYNC_EVT_CNT_EN defined:
  - evt_cnt[i] increments by 1 per event.
  - Saturates at 2^CNT_W-1 and holds there.
  - clr[i] sets it to 0; clr and event in the same cycle gives 1.
- Not defined: no counter registers; evt_cnt is tied to 0. The port is still present so instantiations are unchanged.

Test Plan:
- Reset release with evt_in=4'b1111, NSYNC=2, mode 0 -> armed rises on the 3rd edge; no evt_pulse/evt_pend at any time; all outputs 0 during reset.
- Mode 0, evt_in[2] toggles 0->1 then 1->0 ten cycles later -> two single-cycle evt_pulse[2], each 3 edges after its change; evt_pend[2]=1; overrun[2]=1 after the second event; other channels 0.
- Mode 1, evt_in[0] pulses high for 8 cycles -> exactly one evt_pulse[0] (on rise), none on fall; mode 2 bench -> pulse only on fall.
- clr[1] asserted in the same cycle as evt_pulse[1] with pend=1 -> next cycle evt_pend[1]=1, overrun[1]=0; evt_cnt[1]=1 (counter build).
- Counter build, CNT_W=4: 20 spaced events on ch3 -> evt_cnt[3] = 15 and holds; clr[3] -> 0; without the macro evt_cnt stays 0 throughout.
- rst_n pulsed low mid-stream while evt_pulse[0] is high -> outputs drop to 0 immediately (async); priming restarts; no stale pulse after release.
